// File: rtl/exibe_pkg.sv
// Shared definitions for the sequence presenter: state codes and timing defaults.
package exibe_pkg;

  localparam int unsigned ON_CYCLES_DEF  = 4;
  localparam int unsigned OFF_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    PROXIMO = 3'd4,
    FINAL   = 3'd5
  } estado_t;

  // Timer width: enough bits to reach the longer of the two phases, never below 1.
  function automatic int unsigned largura_timer(input int unsigned on_c, input int unsigned off_c);
    int unsigned maior;
    int unsigned w;
    maior = (on_c > off_c) ? on_c : off_c;
    w = $clog2(maior);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// Up-counter with synchronous clear and enable; flags when it equals the target.
module contador_tempo #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_limpa,
  input  logic         i_habilita,
  input  logic [W-1:0] i_alvo,
  output logic         o_fim_c
);

  logic [W-1:0] r_cont;

  // Count register: clear wins over enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cont <= '0;
    end else if (i_limpa) begin
      r_cont <= '0;
    end else if (i_habilita) begin
      r_cont <= r_cont + W'(1);
    end
  end

  assign o_fim_c = (r_cont == i_alvo);

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence presenter: walks memory positions 0..limite and flashes each move on the LEDs.
module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
  parameter int unsigned OFF_CYCLES = OFF_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              mostrando,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  localparam int unsigned TW = largura_timer(ON_CYCLES, OFF_CYCLES);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_limite;
  logic [DATA_W-1:0] r_leds;
  logic              r_mostrando;
  logic              r_pronto;
  logic [TW-1:0]     w_alvo;
  logic              w_fim_c;
  logic              w_limpa;
  logic              w_habilita;
  logic              w_entra_carrega;
  logic              w_entra_acende;
  logic              w_entra_apaga;
  logic              w_entra_proximo;

  // Timer target follows the current phase; it only runs while lit or dark.
  assign w_alvo     = (r_estado == APAGA) ? TW'(OFF_CYCLES - 1) : TW'(ON_CYCLES - 1);
  assign w_habilita = (r_estado == ACENDE) || (r_estado == APAGA);
  assign w_limpa    = (w_prox != r_estado);

  contador_tempo #(
    .W(TW)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_limpa    (w_limpa),
    .i_habilita (w_habilita),
    .i_alvo     (w_alvo),
    .o_fim_c    (w_fim_c)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL: if (iniciar) w_prox = CARREGA;
      CARREGA: w_prox = ACENDE;
      ACENDE:  if (w_fim_c) w_prox = APAGA;
      APAGA: begin
        if (w_fim_c) begin
          w_prox = (r_endereco == r_limite) ? FINAL : PROXIMO;
        end
      end
      PROXIMO: w_prox = ACENDE;
      FINAL:   if (iniciar) w_prox = CARREGA;
      default: w_prox = INICIAL;
    endcase
  end

  assign w_entra_carrega = (w_prox == CARREGA) && (r_estado != CARREGA);
  assign w_entra_acende  = (w_prox == ACENDE)  && (r_estado != ACENDE);
  assign w_entra_apaga   = (w_prox == APAGA)   && (r_estado != APAGA);
  assign w_entra_proximo = (w_prox == PROXIMO) && (r_estado != PROXIMO);

  // Datapath and status registers, updated on the edge that enters each state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_endereco  <= '0;
      r_limite    <= '0;
      r_leds      <= '0;
      r_mostrando <= 1'b0;
      r_pronto    <= 1'b0;
    end else begin
      if (w_entra_carrega) begin
        r_endereco <= '0;
        r_limite   <= limite;
      end else if (w_entra_proximo) begin
        r_endereco <= r_endereco + ADDR_W'(1);
      end
      if (w_entra_acende) begin
        r_leds <= mem_dado;
      end else if (w_entra_apaga) begin
        r_leds <= '0;
      end
      r_mostrando <= (w_prox == CARREGA) || (w_prox == ACENDE) ||
                     (w_prox == APAGA)   || (w_prox == PROXIMO);
      r_pronto    <= (w_prox == FINAL);
    end
  end

  assign mem_endereco = r_endereco;
  assign leds         = r_leds;
  assign mostrando    = r_mostrando;
  assign pronto       = r_pronto;
  assign db_estado    = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: per-cycle trace compared against a rule-derived model.
module tb_exibe_sequencia;

  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] limite  = 4'd0;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       mostrando;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] addr;
    logic       most;
    logic       pr;
    logic [2:0] est;
  } obs_t;
  typedef obs_t obs_q_t[$];

  obs_t obs;

  always #5 clock = ~clock;

  assign mem_dado = mem[mem_endereco];
  assign obs = {leds, mem_endereco, mostrando, pronto, db_estado};

  exibe_sequencia #(
    .DATA_W(4), .ADDR_W(4), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .iniciar      (iniciar),
    .limite       (limite),
    .mem_dado     (mem_dado),
    .mem_endereco (mem_endereco),
    .leds         (leds),
    .mostrando    (mostrando),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  function automatic string fmt(input obs_t o);
    return $sformatf("leds=%h addr=%0d most=%b pronto=%b estado=%0d", o.leds, o.addr, o.most, o.pr, o.est);
  endfunction

  // Expected per-cycle outputs, starting with the cycle after the edge that samples iniciar.
  function automatic obs_q_t build_exp(input int lim);
    obs_q_t q;
    q.push_back({4'd0, 4'd0, 1'b1, 1'b0, 3'd1});
    for (int p = 0; p <= lim; p++) begin
      for (int c = 0; c < ON; c++)  q.push_back({mem[p], 4'(p), 1'b1, 1'b0, 3'd2});
      for (int c = 0; c < OFF; c++) q.push_back({4'd0, 4'(p), 1'b1, 1'b0, 3'd3});
      if (p < lim) q.push_back({4'd0, 4'(p + 1), 1'b1, 1'b0, 3'd4});
    end
    q.push_back({4'd0, 4'(lim), 1'b0, 1'b1, 3'd5});
    return q;
  endfunction

  // Raise iniciar for exactly one sampling edge.
  task automatic start(input int lim);
    iniciar = 1'b1;
    limite  = 4'(lim);
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (obs !== obs_t'(0)) $display("FAIL reset_hold got %s exp all zero", fmt(obs));
    else n_pass++;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      n_checks++;
      if (obs !== obs_t'(0)) $display("FAIL idle_after_reset got %s exp all zero", fmt(obs));
      else n_pass++;
    end
    mem[0] = 4'hA;
    start(0);
    repeat (2) @(negedge clock);
    n_checks++;
    if (leds !== 4'hA || db_estado !== 3'd2) $display("FAIL pre_reset_acende got %s exp leds=a estado=2", fmt(obs));
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== obs_t'(0)) $display("FAIL async_reset got %s exp all zero", fmt(obs));
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (obs !== obs_t'(0)) $display("FAIL stay_inicial got %s exp all zero", fmt(obs));
      else n_pass++;
    end
  endtask

  task automatic test_single();
    obs_q_t e;
    int first_pr = -1;
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    mem[0] = 4'b0010;
    e = build_exp(0);
    start(0);
    foreach (e[i]) begin
      @(negedge clock);
      n_checks++;
      if (obs !== e[i]) $display("FAIL single idx=%0d got %s exp %s", i, fmt(obs), fmt(e[i]));
      else n_pass++;
      if (pronto === 1'b1 && first_pr < 0) first_pr = i;
    end
    n_checks++;
    if (first_pr != 7) $display("FAIL single_latency got %0d exp 7", first_pr);
    else n_pass++;
  endtask

  task automatic test_three();
    obs_q_t e;
    int first_pr = -1;
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    e = build_exp(2);
    start(2);
    foreach (e[i]) begin
      @(negedge clock);
      n_checks++;
      if (obs !== e[i]) $display("FAIL three idx=%0d got %s exp %s", i, fmt(obs), fmt(e[i]));
      else n_pass++;
      if (pronto === 1'b1 && first_pr < 0) first_pr = i;
    end
    n_checks++;
    if (first_pr != 21) $display("FAIL three_latency got %0d exp 21", first_pr);
    else n_pass++;
  endtask

  task automatic test_ignored_inputs();
    obs_q_t e;
    for (int i = 0; i < 3; i++) mem[i] = 4'($urandom_range(1, 15));
    e = build_exp(2);
    start(2);
    foreach (e[i]) begin
      @(negedge clock);
      n_checks++;
      if (obs !== e[i]) $display("FAIL ignored idx=%0d got %s exp %s", i, fmt(obs), fmt(e[i]));
      else n_pass++;
      iniciar = (e[i].est == 3'd3);
      if (i == 3) limite = 4'd0;
    end
    iniciar = 1'b0;
  endtask

  task automatic test_restart();
    obs_q_t e;
    n_checks++;
    if (pronto !== 1'b1) $display("FAIL restart_pre got pronto=%b exp 1", pronto);
    else n_pass++;
    e = build_exp(2);
    start(2);
    foreach (e[i]) begin
      @(negedge clock);
      n_checks++;
      if (obs !== e[i]) $display("FAIL restart idx=%0d got %s exp %s", i, fmt(obs), fmt(e[i]));
      else n_pass++;
    end
  endtask

  task automatic test_full_range();
    obs_q_t e;
    int first_pr = -1;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    e = build_exp(15);
    start(15);
    foreach (e[i]) begin
      @(negedge clock);
      n_checks++;
      if (obs !== e[i]) $display("FAIL full idx=%0d got %s exp %s", i, fmt(obs), fmt(e[i]));
      else n_pass++;
      if (pronto === 1'b1 && first_pr < 0) first_pr = i;
    end
    n_checks++;
    if (first_pr != 1 + 16 * (ON + OFF) + 15) $display("FAIL full_latency got %0d exp 112", first_pr);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_q_t e;
    int lim;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      lim = int'($urandom_range(0, 15));
      e = build_exp(lim);
      start(lim);
      foreach (e[i]) begin
        @(negedge clock);
        n_checks++;
        if (obs !== e[i]) $display("FAIL random run=%0d lim=%0d idx=%0d got %s exp %s", r, lim, i, fmt(obs), fmt(e[i]));
        else n_pass++;
        iniciar = e[i].most & ($urandom_range(0, 3) == 0);
      end
      iniciar = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    test_reset();
    test_single();
    test_three();
    test_ignored_inputs();
    test_restart();
    test_full_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
